// File: rtl/tms1x00_pkg.sv
// rtl/tms1x00_pkg.sv - shared types, opcode constants and PC sequencing for the TMS1x00 core
// Contents: phase_t (FETCH/EXEC), O-PLA/R widths, fixed opcode constants,
// pc_next() which yields the successor program counter.
// Optional build macro: TMS1X00_LFSR_PC_EN selects the original feedback PC sequence.
package tms1x00_pkg;

  typedef enum logic {
    FETCH = 1'b0,
    EXEC  = 1'b1
  } phase_t;

  localparam int O_PLA_W = 8;
  localparam int R_W     = 16;

  // Single-code opcodes; ranged groups (LDP, LDX, SBIT.., TCY, YNEC, TCMIY,
  // AC1AAC, BR, CALL) are matched by bit pattern in the decoder.
  localparam logic [7:0] OP_MNEA   = 8'h00;
  localparam logic [7:0] OP_ALEM   = 8'h01;
  localparam logic [7:0] OP_YNEA   = 8'h02;
  localparam logic [7:0] OP_XMA    = 8'h03;
  localparam logic [7:0] OP_DYN    = 8'h04;
  localparam logic [7:0] OP_IYC    = 8'h05;
  localparam logic [7:0] OP_AMAAC  = 8'h06;
  localparam logic [7:0] OP_DMAN   = 8'h07;
  localparam logic [7:0] OP_TKA    = 8'h08;
  localparam logic [7:0] OP_COMX   = 8'h09;
  localparam logic [7:0] OP_TDO    = 8'h0A;
  localparam logic [7:0] OP_COMC   = 8'h0B;
  localparam logic [7:0] OP_RSTR   = 8'h0C;
  localparam logic [7:0] OP_SETR   = 8'h0D;
  localparam logic [7:0] OP_KNEZ   = 8'h0E;
  localparam logic [7:0] OP_RETN   = 8'h0F;
  localparam logic [7:0] OP_TAY    = 8'h20;
  localparam logic [7:0] OP_TMA    = 8'h21;
  localparam logic [7:0] OP_TMY    = 8'h22;
  localparam logic [7:0] OP_TYA    = 8'h23;
  localparam logic [7:0] OP_TAMDYN = 8'h24;
  localparam logic [7:0] OP_TAMIYC = 8'h25;
  localparam logic [7:0] OP_TAMZA  = 8'h26;
  localparam logic [7:0] OP_TAM    = 8'h27;
  localparam logic [7:0] OP_SAMAN  = 8'h3C;
  localparam logic [7:0] OP_CPAIZ  = 8'h3D;
  localparam logic [7:0] OP_IMAC   = 8'h3E;
  localparam logic [7:0] OP_MNEZ   = 8'h3F;
  localparam logic [7:0] OP_CLA    = 8'h7F;

  function automatic logic [5:0] pc_next(input logic [5:0] pc);
`ifdef TMS1X00_LFSR_PC_EN
    logic fb;
    if (pc == 6'h3F)      fb = 1'b0;
    else if (pc == 6'h1F) fb = 1'b1;
    else                  fb = ~(pc[5] ^ pc[4]);
    return {pc[4:0], fb};
`else
    return pc + 6'd1;
`endif
  endfunction

endpackage

// File: rtl/tms1x00_alu.sv
// rtl/tms1x00_alu.sv - 4-bit adder/comparator for the TMS1x00 core
// Ports: a, b (4-bit operands), cin (carry in);
//        result = a+b+cin [3:0], carry = bit 4 of that sum, ne = (a != b).
// Subtraction is performed by the caller as a + ~b + 1 (carry = no borrow).
module tms1x00_alu (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] result,
  output logic       carry,
  output logic       ne
);

  logic [4:0] sum;

  assign sum    = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
  assign result = sum[3:0];
  assign carry  = sum[4];
  assign ne     = (a != b);

endmodule

// File: rtl/tms1x00_core.sv
// rtl/tms1x00_core.sv - TMS1100-class 4-bit microcontroller core (two clks per instruction)
// Ports: clk, reset_n (async active-low), chip_sel_i (run enable), K_in[3:0],
//        O_out[7:0], R_out[15:0], rom_addr[10:0] = {CA,PA,PC}, rom_value_raw[7:0]
//        (valid one clk after rom_addr changes), chip_sel_o (chip_sel_i delayed),
//        wb_override/wb_step (debug single-step), status_d, X_d[2:0].
// Build option: TMS1X00_LFSR_PC_EN (feedback PC sequence, see tms1x00_pkg).
module tms1x00_core
  import tms1x00_pkg::*;
#(
  parameter int RAM_WORDS = 128
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                chip_sel_i,
  input  logic [3:0]          K_in,
  output logic [O_PLA_W-1:0]  O_out,
  output logic [R_W-1:0]      R_out,
  output logic [10:0]         rom_addr,
  input  logic [7:0]          rom_value_raw,
  output logic                chip_sel_o,
  input  logic                wb_override,
  input  logic                wb_step,
  output logic                status_d,
  output logic [2:0]          X_d
);

  phase_t phase, phase_n;
  logic [3:0] a_r, a_n, y_r, y_n, pb_r, pb_n, pa_r, pa_n;
  logic [2:0] x_r, x_n;
  logic [5:0] pc_r, pc_n, sr_r, sr_n, pc_inc;
  logic st_r, st_n, sl_r, sl_n, ca_r, ca_n, cb_r, cb_n, cs_r, cs_n, cl_r, cl_n;
  logic [O_PLA_W-1:0] o_n;
  logic [R_W-1:0] r_n;
  logic wb_step_q, step_latch, exec_done;
  logic [3:0] ram [RAM_WORDS];
  logic [3:0] m, ram_wd, alu_a, alu_b, alu_res, mask;
  logic ram_we, alu_cin, alu_carry, alu_ne;
  logic [7:0] op;

  assign op        = rom_value_raw;
  assign m         = ram[{x_r, y_r}];
  assign mask      = 4'b0001 << op[1:0];
  assign pc_inc    = pc_next(pc_r);
  assign exec_done = (phase == EXEC) && chip_sel_i;
  assign rom_addr  = {ca_r, pa_r, pc_r};
  assign status_d  = st_r;
  assign X_d       = x_r;

  tms1x00_alu u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .cin    (alu_cin),
    .result (alu_res),
    .carry  (alu_carry),
    .ne     (alu_ne)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) phase <= FETCH;
    else          phase <= phase_n;
  end

  // In debug mode a fetch only proceeds once a wb_step edge has been seen.
  always_comb begin
    phase_n = phase;
    case (phase)
      FETCH: if (chip_sel_i && (!wb_override || step_latch)) phase_n = EXEC;
      EXEC:  if (chip_sel_i) phase_n = FETCH;
      default: phase_n = FETCH;
    endcase
  end

  // ALU operand routing; subtracts use a + ~b + 1 so carry means "no borrow".
  always_comb begin
    alu_a = m; alu_b = a_r; alu_cin = 1'b0;
    casez (op)
      OP_ALEM, OP_SAMAN:            begin alu_a = m;     alu_b = ~a_r;   alu_cin = 1'b1; end
      OP_YNEA:                      begin alu_a = y_r;   alu_b = a_r;    end
      OP_DYN, OP_TAMDYN:            begin alu_a = y_r;   alu_b = 4'hF;   end
      OP_IYC, OP_TAMIYC:            begin alu_a = y_r;   alu_b = 4'h0;   alu_cin = 1'b1; end
      OP_AMAAC:                     begin alu_a = a_r;   alu_b = m;      end
      OP_DMAN:                      begin alu_a = m;     alu_b = 4'hF;   end
      OP_KNEZ:                      begin alu_a = K_in;  alu_b = 4'h0;   end
      OP_CPAIZ:                     begin alu_a = ~a_r;  alu_b = 4'h0;   alu_cin = 1'b1; end
      OP_IMAC:                      begin alu_a = m;     alu_b = 4'h0;   alu_cin = 1'b1; end
      OP_MNEZ:                      begin alu_a = m;     alu_b = 4'h0;   end
      8'b0101_????:                 begin alu_a = y_r;   alu_b = op[3:0]; end
      8'b0110_????:                 begin alu_a = y_r;   alu_b = 4'h0;   alu_cin = 1'b1; end
      8'b0111_????:                 begin alu_a = a_r;   alu_b = op[3:0]; alu_cin = 1'b1; end
      default: ;
    endcase
  end

  always_comb begin
    a_n = a_r; y_n = y_r; x_n = x_r; st_n = 1'b1; sl_n = sl_r;
    pc_n = pc_inc; pa_n = pa_r; pb_n = pb_r; ca_n = ca_r; cb_n = cb_r;
    cs_n = cs_r; sr_n = sr_r; cl_n = cl_r; o_n = O_out; r_n = R_out;
    ram_we = 1'b0; ram_wd = a_r;
    casez (op)
      OP_MNEA, OP_YNEA:                 begin st_n = alu_ne; sl_n = alu_ne; end
      OP_ALEM:                          st_n = alu_carry;
      OP_XMA:                           begin a_n = m; ram_we = 1'b1; end
      OP_DYN, OP_IYC:                   begin y_n = alu_res; st_n = alu_carry; end
      OP_AMAAC, OP_DMAN, OP_SAMAN,
      OP_CPAIZ, OP_IMAC:                begin a_n = alu_res; st_n = alu_carry; end
      OP_TKA:                           a_n = K_in;
      OP_COMX:                          x_n = ~x_r;
      OP_TDO:                           o_n = {{(O_PLA_W-5){1'b0}}, sl_r, a_r};
      OP_COMC:                          cb_n = ~cb_r;
      OP_RSTR:                          r_n[y_r] = 1'b0;
      OP_SETR:                          r_n[y_r] = 1'b1;
      OP_KNEZ, OP_MNEZ:                 st_n = alu_ne;
      OP_RETN:                          begin pc_n = sr_r; pa_n = pb_r; ca_n = cs_r; cl_n = 1'b0; end
      8'b0001_????:                     pb_n = op[3:0];
      OP_TAY:                           y_n = a_r;
      OP_TMA:                           a_n = m;
      OP_TMY:                           y_n = m;
      OP_TYA:                           a_n = y_r;
      OP_TAMDYN, OP_TAMIYC:             begin ram_we = 1'b1; y_n = alu_res; st_n = alu_carry; end
      OP_TAMZA:                         begin ram_we = 1'b1; a_n = 4'h0; end
      OP_TAM:                           ram_we = 1'b1;
      8'b0010_1???:                     x_n = op[2:0];
      8'b0011_00??:                     begin ram_we = 1'b1; ram_wd = m | mask; end
      8'b0011_01??:                     begin ram_we = 1'b1; ram_wd = m & ~mask; end
      8'b0011_10??:                     st_n = m[op[1:0]];
      8'b0100_????:                     y_n = op[3:0];
      8'b0101_????:                     begin st_n = alu_ne; sl_n = alu_ne; end
      8'b0110_????:                     begin ram_we = 1'b1; ram_wd = op[3:0]; y_n = alu_res; end
      OP_CLA:                           a_n = 4'h0;
      8'b0111_????:                     begin a_n = alu_res; st_n = alu_carry; end
      8'b10??_????: if (st_r) begin
        pc_n = op[5:0]; pa_n = pb_r; ca_n = cb_r;
      end
      8'b11??_????: if (st_r) begin
        pc_n = op[5:0]; pa_n = pb_r; ca_n = cb_r;
        // First-level call saves the return point; a nested call is a plain branch.
        if (!cl_r) begin
          sr_n = pc_inc; cs_n = ca_r; pb_n = pa_r; cl_n = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_r <= '0; y_r <= '0; x_r <= '0; st_r <= 1'b1; sl_r <= 1'b0;
      pc_r <= '0; pa_r <= '0; pb_r <= '0; ca_r <= 1'b0; cb_r <= 1'b0;
      cs_r <= 1'b0; sr_r <= '0; cl_r <= 1'b0; O_out <= '0; R_out <= '0;
      chip_sel_o <= 1'b0; wb_step_q <= 1'b0; step_latch <= 1'b0;
    end else begin
      chip_sel_o <= chip_sel_i;
      wb_step_q  <= wb_step;
      step_latch <= (wb_step && !wb_step_q) || (step_latch && !exec_done);
      if (exec_done) begin
        a_r <= a_n; y_r <= y_n; x_r <= x_n; st_r <= st_n; sl_r <= sl_n;
        pc_r <= pc_n; pa_r <= pa_n; pb_r <= pb_n; ca_r <= ca_n; cb_r <= cb_n;
        cs_r <= cs_n; sr_r <= sr_n; cl_r <= cl_n; O_out <= o_n; R_out <= r_n;
      end
    end
  end

  // Data RAM has no reset; the write uses the pre-instruction {X,Y} address.
  always_ff @(posedge clk) begin
    if (exec_done && ram_we) ram[{x_r, y_r}] <= ram_wd;
  end

endmodule

// File: tb/tb_tms1x00_core.sv
// tb/tb_tms1x00_core.sv - directed self-checking bench for tms1x00_core
module tb_tms1x00_core;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        chip_sel_i = 1'b1;
  logic [3:0]  K_in = 4'h0;
  logic [7:0]  O_out;
  logic [15:0] R_out;
  logic [10:0] rom_addr;
  logic [7:0]  rom_q = 8'h7F;
  logic        chip_sel_o;
  logic        wb_override = 1'b0;
  logic        wb_step = 1'b0;
  logic        status_d;
  logic [2:0]  X_d;

  logic [7:0] rom [2048];
  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  always @(posedge clk) rom_q <= rom[rom_addr];

  tms1x00_core dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .chip_sel_i    (chip_sel_i),
    .K_in          (K_in),
    .O_out         (O_out),
    .R_out         (R_out),
    .rom_addr      (rom_addr),
    .rom_value_raw (rom_q),
    .chip_sel_o    (chip_sel_o),
    .wb_override   (wb_override),
    .wb_step       (wb_step),
    .status_d      (status_d),
    .X_d           (X_d)
  );

  task automatic clear_rom();
    for (int i = 0; i < 2048; i++) rom[i] = 8'h7F;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic run(input int n);
    repeat (2 * n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_rom();
    do_reset();
    total_cnt++; if (rom_addr !== 11'h000) $display("FAIL reset_rom_addr got %h want 000", rom_addr); else pass_cnt++;
    total_cnt++; if (O_out !== 8'h00) $display("FAIL reset_o got %h want 00", O_out); else pass_cnt++;
    total_cnt++; if (R_out !== 16'h0000) $display("FAIL reset_r got %h want 0000", R_out); else pass_cnt++;
    total_cnt++; if (status_d !== 1'b1) $display("FAIL reset_status got %b want 1", status_d); else pass_cnt++;
    total_cnt++; if (X_d !== 3'd0) $display("FAIL reset_x got %0d want 0", X_d); else pass_cnt++;
    total_cnt++; if (chip_sel_o !== 1'b0) $display("FAIL reset_cso got %b want 0", chip_sel_o); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (chip_sel_o !== 1'b1) $display("FAIL cso_after_release got %b want 1", chip_sel_o); else pass_cnt++;
  endtask

  task automatic test_setr_rstr();
    clear_rom();
    rom[0] = 8'h45; rom[1] = 8'h0D; rom[2] = 8'h4F; rom[3] = 8'h0D; rom[4] = 8'h45; rom[5] = 8'h0C;
    do_reset();
    run(2);
    total_cnt++; if (R_out !== 16'h0020) $display("FAIL setr5 got %h want 0020", R_out); else pass_cnt++;
    run(2);
    total_cnt++; if (R_out !== 16'h8020) $display("FAIL setr15 got %h want 8020", R_out); else pass_cnt++;
    run(2);
    total_cnt++; if (R_out !== 16'h8000) $display("FAIL rstr5 got %h want 8000", R_out); else pass_cnt++;
    total_cnt++; if (rom_addr !== 11'h006) $display("FAIL setr_pc got %h want 006", rom_addr); else pass_cnt++;
  endtask

  task automatic test_tdo();
    clear_rom();
    rom[0] = 8'h43; rom[1] = 8'h23; rom[2] = 8'h53; rom[3] = 8'h0A;
    do_reset();
    run(3);
    total_cnt++; if (status_d !== 1'b0) $display("FAIL ynec_eq_status got %b want 0", status_d); else pass_cnt++;
    run(1);
    total_cnt++; if (O_out !== 8'h03) $display("FAIL tdo_sl0 got %h want 03", O_out); else pass_cnt++;
    clear_rom();
    rom[0] = 8'h43; rom[1] = 8'h23; rom[2] = 8'h54; rom[3] = 8'h0A;
    do_reset();
    run(4);
    total_cnt++; if (O_out !== 8'h13) $display("FAIL tdo_sl1 got %h want 13", O_out); else pass_cnt++;
  endtask

  task automatic test_alu();
    clear_rom();
    rom[0] = 8'h7B; rom[1] = 8'h27; rom[2] = 8'h06; rom[3] = 8'h0A;
    rom[4] = 8'h07; rom[5] = 8'h3D; rom[6] = 8'h0A;
    do_reset();
    run(1);
    total_cnt++; if (status_d !== 1'b0) $display("FAIL ac1aac_nocarry got %b want 0", status_d); else pass_cnt++;
    run(2);
    total_cnt++; if (status_d !== 1'b1) $display("FAIL amaac_carry got %b want 1", status_d); else pass_cnt++;
    run(1);
    total_cnt++; if (O_out !== 8'h08) $display("FAIL amaac_sum got %h want 08", O_out); else pass_cnt++;
    run(2);
    total_cnt++; if (status_d !== 1'b0) $display("FAIL cpaiz_status got %b want 0", status_d); else pass_cnt++;
    run(1);
    total_cnt++; if (O_out !== 8'h05) $display("FAIL dman_cpaiz got %h want 05", O_out); else pass_cnt++;
  endtask

  task automatic test_branch();
    clear_rom();
    rom[0] = 8'h12; rom[1] = 8'h90;
    do_reset();
    run(2);
    total_cnt++; if (rom_addr !== 11'h090) $display("FAIL br_taken got %h want 090", rom_addr); else pass_cnt++;
    clear_rom();
    rom[0] = 8'h12; rom[1] = 8'h0E; rom[2] = 8'h90;
    K_in = 4'h0;
    do_reset();
    run(3);
    total_cnt++; if (rom_addr !== 11'h003) $display("FAIL br_not_taken got %h want 003", rom_addr); else pass_cnt++;
    K_in = 4'h4;
    do_reset();
    run(3);
    total_cnt++; if (rom_addr !== 11'h090) $display("FAIL br_knez_taken got %h want 090", rom_addr); else pass_cnt++;
    K_in = 4'h0;
  endtask

  task automatic test_call_retn();
    clear_rom();
    rom[0] = 8'h11; rom[1] = 8'hE0; rom[11'h060] = 8'h0F;
    do_reset();
    run(2);
    total_cnt++; if (rom_addr !== 11'h060) $display("FAIL call_target got %h want 060", rom_addr); else pass_cnt++;
    run(1);
    total_cnt++; if (rom_addr !== 11'h002) $display("FAIL retn_addr got %h want 002", rom_addr); else pass_cnt++;
  endtask

  task automatic test_debug_step();
    clear_rom();
    rom[0] = 8'h2D; rom[1] = 8'h09;
    wb_override = 1'b1;
    do_reset();
    repeat (10) @(posedge clk); #1;
    total_cnt++; if (rom_addr !== 11'h000) $display("FAIL dbg_hold_addr got %h want 000", rom_addr); else pass_cnt++;
    total_cnt++; if (X_d !== 3'd0) $display("FAIL dbg_hold_x got %0d want 0", X_d); else pass_cnt++;
    @(negedge clk) wb_step = 1'b1;
    @(negedge clk) wb_step = 1'b0;
    repeat (6) @(posedge clk); #1;
    total_cnt++; if (X_d !== 3'd5) $display("FAIL dbg_ldx got %0d want 5", X_d); else pass_cnt++;
    total_cnt++; if (rom_addr !== 11'h001) $display("FAIL dbg_step1_addr got %h want 001", rom_addr); else pass_cnt++;
    @(negedge clk) wb_step = 1'b1;
    repeat (3) @(negedge clk);
    wb_step = 1'b0;
    repeat (6) @(posedge clk); #1;
    total_cnt++; if (X_d !== 3'd2) $display("FAIL dbg_comx got %0d want 2", X_d); else pass_cnt++;
    total_cnt++; if (rom_addr !== 11'h002) $display("FAIL dbg_step2_addr got %h want 002", rom_addr); else pass_cnt++;
    wb_override = 1'b0;
  endtask

  task automatic test_freeze();
    clear_rom();
    rom[0] = 8'h41; rom[1] = 8'h2B; rom[2] = 8'h42;
    do_reset();
    run(1);
    chip_sel_i = 1'b0;
    repeat (7) @(posedge clk); #1;
    total_cnt++; if (rom_addr !== 11'h001) $display("FAIL freeze_addr got %h want 001", rom_addr); else pass_cnt++;
    total_cnt++; if (X_d !== 3'd0) $display("FAIL freeze_x got %0d want 0", X_d); else pass_cnt++;
    total_cnt++; if (chip_sel_o !== 1'b0) $display("FAIL freeze_cso got %b want 0", chip_sel_o); else pass_cnt++;
    chip_sel_i = 1'b1;
    run(1);
    total_cnt++; if (X_d !== 3'd3) $display("FAIL resume_x got %0d want 3", X_d); else pass_cnt++;
    total_cnt++; if (rom_addr !== 11'h002) $display("FAIL resume_addr got %h want 002", rom_addr); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_setr_rstr();
    test_tdo();
    test_alu();
    test_branch();
    test_call_retn();
    test_debug_step();
    test_freeze();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/tms1x00_core.md
Name: tms1x00_core

Overview:
- 4-bit TMS1100-class microcontroller core. Executes an 8-bit fixed TMS1100 instruction set from an external byte-wide ROM with a 2 KiB address space.
- Internal 128x4 data RAM.
- Drives 8 O outputs and 16 R outputs; reads 4 K inputs.
- Sits inside the chip wrapper. That wrapper supplies ROM bytes from a synchronous SRAM and optional debug single-step control.

Parameters:
- RAM_WORDS, 128, number of 4-bit data RAM nibbles; addressed as {X[2:0], Y[3:0]}.

Ports:
- clk  in  1  core clock.
- reset_n  in  1  asynchronous active-low reset.
- chip_sel_i  in  1  run enable; 0 freezes the core.
- K_in  in  4  K input lines.
- O_out  out  8  O output latch.
- R_out  out  16  R output latches.
- rom_addr  out  11  ROM byte address {CA, PA[3:0], PC[5:0]}.
- rom_value_raw  in  8  ROM byte; valid one clk after rom_addr changes.
- chip_sel_o  out  1  chip_sel_i registered once (daisy chain).
- wb_override  in  1  debug mode; execution advances only on wb_step.
- wb_step  in  1  debug step request; a rising edge permits one instruction.
- status_d  out  1  current status flag.
- X_d  out  3  current X register.

Behaviour:
- Reset (async, reset_n=0): A=0, Y=0, X=0, status=1, SL=0, PC=0, PA=PB=0, CA=CB=CS=0, SR=0, CL=0, O_out=0, R_out=0, chip_sel_o=0, phase=FETCH, step latch=0.
- Instruction cycle is two clks:
  - FETCH: rom_addr is stable.
  - EXEC: latch rom_value_raw, execute it, update PC.
- Throughput is one instruction per 2 clks.
- Advance conditions:
  - Phase advances only when chip_sel_i=1.
  - In debug mode (wb_override=1), the transition FETCH→EXEC also requires the step latch.
  - The step latch is set on a wb_step rising edge and cleared when EXEC completes.
- Default PC update: PC+1 mod 64. PA and CA are unchanged.
- Status is 1 after every instruction unless a rule below states otherwise.
- M denotes RAM[{X,Y}].
- 00 MNEA: status = (M≠A). SL←status.
- 01 ALEM: status = (A≤M).
- 02 YNEA: status = (Y≠A). SL←status.
- 03 XMA: swap M and A.
- 04 DYN: Y−1; status = no borrow (Y≠0 before).
- 05 IYC: Y+1; status = carry.
- 06 AMAAC: A←A+M; status = carry.
- 07 DMAN: A←M−1; status = (M≠0).
- 08 TKA: A←K_in.
- 09 COMX: X←~X.
- 0A TDO: O_out←{3'b0, SL, A}.
- 0B COMC: CB←~CB.
- 0C RSTR: R_out[Y]←0.
- 0D SETR: R_out[Y]←1.
- 0E KNEZ: status = (K_in≠0).
- 0F RETN: PC←SR, PA←PB, CA←CS, CL←0.
- 10–1F LDP: PB←op[3:0].
- 20 TAY: Y←A.
- 21 TMA: A←M.
- 22 TMY: Y←M.
- 23 TYA: A←Y.
- 24 TAMDYN: M←A, then Y−1; status = no borrow.
- 25 TAMIYC: M←A, then Y+1; status = carry.
- 26 TAMZA: M←A, A←0.
- 27 TAM: M←A.
- 28–2F LDX: X←op[2:0].
- 30–33 SBIT: M[op[1:0]]←1.
- 34–37 RBIT: M[op[1:0]]←0.
- 38–3B TBIT1: status = M[op[1:0]].
- 3C SAMAN: A←M−A; status = no borrow.
- 3D CPAIZ: A←−A; status = (A==0 before).
- 3E IMAC: A←M+1; status = carry.
- 3F MNEZ: status = (M≠0).
- 40–4F TCY: Y←op[3:0].
- 50–5F YNEC: status = (Y≠op[3:0]). SL←status.
- 60–6F TCMIY: M←op[3:0], then Y+1.
- 70–7E AC1AAC: A←A+op[3:0]+1; status = carry.
- 7F CLA: A←0.
- 80–BF BR:
  - Taken only if status=1: PC←op[5:0], PA←PB, CA←CB.
  - Not taken: normal PC increment.
- C0–FF CALL:
  - Taken only if status=1.
  - If CL=0: SR←PC+1, CS←CA, PB←PA, PA←PB (swap), CA←CB, CL←1, PC←op[5:0].
  - If CL=1: behaves as BR.
- Status for BR/CALL: status is forced to 1 afterwards.
- Arithmetic width: all arithmetic is 4-bit; carry/borrow is bit 4. Y wraps 15↔0.
- RAM: no reset of contents. Reads are combinational; writes happen at the end of EXEC.
- Freeze: chip_sel_i=0 mid-instruction freezes the phase. All state holds and outputs hold.
- status_d and X_d are combinational copies of internal state.

Optional Feature:
- Macro: TMS1X00_LFSR_PC_EN.
- When defined, the PC increment uses the original feedback sequence:
  - next = {PC[4:0], fb}, with fb = ~(PC[5]^PC[4]).
  - Exceptions: PC=6'h3F gives fb=0; PC=6'h1F gives fb=1.
- When undefined, the PC increment is binary +1 mod 64.
- In both cases SR captures the "next" PC from the selected sequence.

Decomposition:
- Package tms1x00_pkg holds:
  - opcode constants/ranges;
  - the phase enum (FETCH, EXEC);
  - the O-PLA width.
- Sub-module tms1x00_alu: 4-bit adder/comparator producing result and status.

Test Plan:
- Reset: release reset_n → rom_addr=0, O_out=0, R_out=0, status_d=1, X_d=0, chip_sel_o=1 one clk after release with chip_sel_i=1.
- SETR/RSTR: ROM {TCY 5, SETR, TCY 15, SETR, TCY 5, RSTR} → R_out=0x0020, then 0x8020, then 0x8000.
- TDO: ROM {TCY 3, TYA, YNEC 3, TDO} → A=3, SL=0, O_out=0x03.
- Branch: {LDP 2, BR 0x10} → next rom_addr=0x090. Same program with preceding KNEZ and K_in=0 → branch not taken, PC increments.
- Call/return: CALL 0x20 with PB=1 at page 0 → rom_addr=0x060; RETN → PC=caller+1, page 0.
- Debug step: wb_override=1, chip_sel_i=1 → rom_addr frozen; each wb_step pulse advances exactly one instruction; LDX 5 → X_d=5.
